// File: rtl/squarewave_hyst.sv
// Hysteresis slicer: signed samples to a debounced square wave,
// with edge pulses and rising-edge period measurement.
module squarewave_hyst #(
  parameter int DATA_W = 14,
  parameter int CNT_W  = 8,
  parameter int PER_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] sigin,
  input  logic signed [DATA_W-1:0] th_hi,
  input  logic signed [DATA_W-1:0] th_lo,
  input  logic        [CNT_W-1:0]  deb_cyc,
  output logic                     sigout,
  output logic                     rise_pulse,
  output logic                     fall_pulse,
  output logic        [PER_W-1:0]  period,
  output logic                     period_vld,
  output logic                     period_ovf
);

  typedef enum logic [1:0] {
    LOW,
    PEND_HI,
    HIGH,
    PEND_LO
  } state_t;

  state_t                    state;
  logic signed [DATA_W-1:0]  x;
  logic        [CNT_W-1:0]   cnt;
  logic        [PER_W-1:0]   pcnt;
  logic                      armed;
  logic                      above;
  logic                      below;
  logic                      go_hi;
  logic                      go_lo;

  // Input sample register, runs regardless of enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) x <= '0;
    else        x <= sigin;
  end

  // Above wins when an inverted band makes both true
  assign above = (x > th_hi);
  assign below = !above && (x < th_lo);

  // Switch decisions, shared by the FSM and the period counter
  always_comb begin
    go_hi = 1'b0;
    go_lo = 1'b0;
    if (en) begin
      go_hi = above && ((state == LOW && deb_cyc == '0) ||
                        (state == PEND_HI && cnt >= deb_cyc));
      go_lo = below && ((state == HIGH && deb_cyc == '0) ||
                        (state == PEND_LO && cnt >= deb_cyc));
    end
  end

  // Slicer FSM with registered square wave and edge pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOW;
      cnt        <= '0;
      sigout     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= go_hi;
      fall_pulse <= go_lo;
      if (go_hi) begin
        state  <= HIGH;
        sigout <= 1'b1;
        cnt    <= '0;
      end else if (go_lo) begin
        state  <= LOW;
        sigout <= 1'b0;
        cnt    <= '0;
      end else if (!en) begin
        cnt <= '0;
        if (state == PEND_HI) state <= LOW;
        if (state == PEND_LO) state <= HIGH;
      end else begin
        unique case (state)
          LOW: begin
            if (above) begin
              state <= PEND_HI;
              cnt   <= CNT_W'(1);
            end
          end
          PEND_HI: begin
            if (!above) begin
              state <= LOW;
              cnt   <= '0;
            end else if (cnt != '1) begin
              cnt <= cnt + 1'b1;
            end
          end
          HIGH: begin
            if (below) begin
              state <= PEND_LO;
              cnt   <= CNT_W'(1);
            end
          end
          PEND_LO: begin
            if (!below) begin
              state <= HIGH;
              cnt   <= '0;
            end else if (cnt != '1) begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Rise-to-rise period counter; count restarts at 1 on each rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt       <= '0;
      armed      <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      period_ovf <= 1'b0;
    end else if (!en) begin
      pcnt       <= '0;
      armed      <= 1'b0;
      period_vld <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      if (go_hi) begin
        pcnt  <= PER_W'(1);
        armed <= 1'b1;
        if (armed) begin
          period     <= pcnt;
          period_vld <= 1'b1;
          period_ovf <= &pcnt;
        end
      end else if (!(&pcnt)) begin
        pcnt <= pcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_squarewave_hyst.sv
// Bench for squarewave_hyst: scheduled expectations
// compared against both a 24-bit and an 8-bit period instance.
module tb_squarewave_hyst;

  localparam int DW = 14;
  localparam int K_SIG  = 0;
  localparam int K_RISE = 1;
  localparam int K_FALL = 2;
  localparam int K_PER  = 3;
  localparam int K_VLD  = 4;
  localparam int K_OVF  = 5;
  localparam int K_PER8 = 6;
  localparam int K_VLD8 = 7;
  localparam int K_OVF8 = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic signed [DW-1:0] sigin;
  logic signed [DW-1:0] th_hi;
  logic signed [DW-1:0] th_lo;
  logic        [7:0]    deb_cyc;
  logic                 sigout, rise_pulse, fall_pulse;
  logic        [23:0]   period;
  logic                 period_vld, period_ovf;
  logic                 sigout8, rise8, fall8;
  logic        [7:0]    period8;
  logic                 vld8, ovf8;

  squarewave_hyst u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sigin      (sigin),
    .th_hi      (th_hi),
    .th_lo      (th_lo),
    .deb_cyc    (deb_cyc),
    .sigout     (sigout),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .period     (period),
    .period_vld (period_vld),
    .period_ovf (period_ovf)
  );

  squarewave_hyst #(.PER_W(8)) u_dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sigin      (sigin),
    .th_hi      (th_hi),
    .th_lo      (th_lo),
    .deb_cyc    (deb_cyc),
    .sigout     (sigout8),
    .rise_pulse (rise8),
    .fall_pulse (fall8),
    .period     (period8),
    .period_vld (vld8),
    .period_ovf (ovf8)
  );

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_rise = 0;
  int   n_fall = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(int k);
    case (k)
      K_SIG:  return 32'(sigout);
      K_RISE: return 32'(rise_pulse);
      K_FALL: return 32'(fall_pulse);
      K_PER:  return 32'(period);
      K_VLD:  return 32'(period_vld);
      K_OVF:  return 32'(period_ovf);
      K_PER8: return 32'(period8);
      K_VLD8: return 32'(vld8);
      K_OVF8: return 32'(ovf8);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic exp_at(int due, int kind, logic [31:0] v, string tag);
    exp_t e;
    int   i;
    e.due = due;
    e.kind = kind;
    e.val = v;
    e.tag = tag;
    i = 0;
    while (i < sbq.size() && sbq[i].due <= due) i++;
    sbq.insert(i, e);
  endtask

  task automatic exp_rise(int t, string tag);
    exp_at(t - 1, K_SIG, 0, {tag, "_pre"});
    exp_at(t, K_SIG, 1, {tag, "_sig"});
    exp_at(t, K_RISE, 1, {tag, "_rise"});
    exp_at(t + 1, K_RISE, 0, {tag, "_rise_end"});
  endtask

  task automatic exp_fall(int t, string tag);
    exp_at(t - 1, K_SIG, 1, {tag, "_pre"});
    exp_at(t, K_SIG, 0, {tag, "_sig"});
    exp_at(t, K_FALL, 1, {tag, "_fall"});
    exp_at(t + 1, K_FALL, 0, {tag, "_fall_end"});
  endtask

  // Pop every expectation due in the current cycle
  always @(negedge clk) begin
    exp_t e;
    if (rise_pulse) n_rise++;
    if (fall_pulse) n_fall++;
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      e = sbq.pop_front();
      chk(e.tag, obs(e.kind), e.val);
    end
  end

  task automatic drv(int v, output int c);
    @(negedge clk);
    sigin = DW'(v);
    c = cyc;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_th(int hi, int lo);
    th_hi = DW'(hi);
    th_lo = DW'(lo);
  endtask

  task automatic en_pulse_low();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c, ca, cb, cc, r0, f0;
    rst_n = 1'b0;
    en = 1'b0;
    sigin = '0;
    set_th(5000, 5001);
    deb_cyc = 8'd0;
    idle(3);
    chk("rst_sigout", 32'(sigout), 0);
    chk("rst_rise", 32'(rise_pulse), 0);
    chk("rst_fall", 32'(fall_pulse), 0);
    chk("rst_period", 32'(period), 0);
    chk("rst_vld", 32'(period_vld), 0);
    chk("rst_ovf", 32'(period_ovf), 0);
    rst_n = 1'b1;
    en = 1'b1;
    sigin = DW'(4999);
    idle(4);

    // Legacy threshold, no debounce
    r0 = n_rise;
    f0 = n_fall;
    drv(5001, c);
    exp_rise(c + 2, "t1");
    exp_at(c + 2, K_VLD, 0, "t1_arm_vld");
    idle(5);
    drv(5000, c);
    exp_fall(c + 2, "t1");
    idle(5);
    chk("t1_nrise", 32'(n_rise - r0), 1);
    chk("t1_nfall", 32'(n_fall - f0), 1);

    // Hysteresis band
    drv(0, c);
    idle(3);
    set_th(1000, -1000);
    idle(3);
    r0 = n_rise;
    f0 = n_fall;
    drv(1001, c);
    exp_rise(c + 2, "t2");
    idle(2);
    drv(0, c);
    exp_at(c + 3, K_SIG, 1, "t2_hold0");
    idle(2);
    drv(500, c);
    exp_at(c + 3, K_SIG, 1, "t2_hold500");
    idle(2);
    drv(-1000, c);
    exp_at(c + 3, K_SIG, 1, "t2_hold_m1000");
    idle(2);
    drv(-1001, c);
    exp_fall(c + 2, "t2");
    idle(5);
    chk("t2_nrise", 32'(n_rise - r0), 1);
    chk("t2_nfall", 32'(n_fall - f0), 1);

    // Debounce
    drv(0, c);
    idle(3);
    set_th(100, -100);
    deb_cyc = 8'd3;
    idle(2);
    r0 = n_rise;
    drv(200, c);
    for (int k = 1; k <= 8; k++) exp_at(c + k, K_SIG, 0, "t3_short");
    idle(2);
    drv(0, c);
    idle(7);
    chk("t3_nrise_short", 32'(n_rise - r0), 0);
    drv(200, c);
    exp_rise(c + 5, "t3_deb");
    idle(7);
    drv(-200, c);
    exp_fall(c + 5, "t3_deb");
    idle(7);
    drv(200, c);
    exp_at(c + 3, K_SIG, 0, "t3_pend");
    idle(3);
    deb_cyc = 8'd1;
    exp_at(c + 4, K_SIG, 1, "t3_lowered");
    idle(4);

    // Full-scale square wave, period 40
    deb_cyc = 8'd0;
    set_th(0, 0);
    idle(2);
    en_pulse_low();
    for (int p = 0; p < 5; p++) begin
      drv(-8000, c);
      idle(19);
      drv(8000, c);
      exp_at(c + 2, K_SIG, 1, "t4_sig");
      exp_at(c + 2, K_VLD, 32'(p > 0), "t4_vld");
      if (p > 0) exp_at(c + 2, K_PER, 40, "t4_per");
      exp_at(c + 2, K_OVF, 0, "t4_ovf");
      exp_at(c + 3, K_VLD, 0, "t4_vld_end");
      idle(19);
    end

    // Negative-only wave, period 30
    drv(-8000, c);
    idle(3);
    set_th(-4000, -4000);
    idle(3);
    en_pulse_low();
    for (int p = 0; p < 3; p++) begin
      drv(-8000, c);
      idle(14);
      drv(-100, c);
      exp_at(c + 2, K_SIG, 1, "t4n_sig");
      exp_at(c + 2, K_VLD, 32'(p > 0), "t4n_vld");
      if (p > 0) exp_at(c + 2, K_PER, 30, "t4n_per");
      idle(14);
    end

    // Period saturation on the 8-bit instance
    drv(-8000, c);
    idle(5);
    en_pulse_low();
    idle(2);
    drv(-100, ca);
    exp_at(ca + 2, K_VLD8, 0, "t5_arm_vld8");
    idle(9);
    drv(-8000, c);
    idle(289);
    drv(-100, cb);
    exp_at(cb + 2, K_PER8, 255, "t5_per8_sat");
    exp_at(cb + 2, K_VLD8, 1, "t5_vld8");
    exp_at(cb + 2, K_OVF8, 1, "t5_ovf8");
    exp_at(cb + 2, K_PER, 300, "t5_per24");
    exp_at(cb + 2, K_OVF, 0, "t5_ovf24");
    exp_at(cb + 10, K_OVF8, 1, "t5_ovf8_sticky");
    idle(9);
    drv(-8000, c);
    idle(39);
    drv(-100, cc);
    exp_at(cc + 2, K_PER8, 50, "t5_per8_50");
    exp_at(cc + 2, K_VLD8, 1, "t5_vld8_50");
    exp_at(cc + 2, K_OVF8, 0, "t5_ovf8_clr");
    idle(9);

    // Enable dropped during PEND_LO
    drv(8000, c);
    idle(3);
    set_th(0, 0);
    deb_cyc = 8'd4;
    idle(3);
    r0 = n_rise;
    f0 = n_fall;
    drv(-8000, c);
    idle(3);
    en = 1'b0;
    for (int k = 4; k <= 10; k++) exp_at(c + k, K_SIG, 1, "t6_en_hold");
    idle(8);
    chk("t6_nfall_en0", 32'(n_fall - f0), 0);
    chk("t6_nrise_en0", 32'(n_rise - r0), 0);
    drv(8000, c);
    idle(2);
    en = 1'b1;
    idle(3);
    drv(-8000, c);
    exp_fall(c + 6, "t6");
    idle(9);
    drv(8000, c);
    exp_rise(c + 6, "t6_arm");
    exp_at(c + 6, K_VLD, 0, "t6_arm_vld");
    idle(19);
    drv(-8000, c);
    idle(19);
    drv(8000, c);
    exp_at(c + 6, K_VLD, 1, "t6_vld");
    exp_at(c + 6, K_PER, 40, "t6_per");
    idle(9);

    // Asynchronous reset during PEND_HI
    drv(-8000, c);
    idle(9);
    drv(8000, c);
    idle(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_sigout", 32'(sigout), 0);
    chk("t6_arst_rise", 32'(rise_pulse), 0);
    chk("t6_arst_period", 32'(period), 0);
    chk("t6_arst_vld", 32'(period_vld), 0);
    chk("t6_arst_ovf", 32'(period_ovf), 0);
    chk("t6_arst_period8", 32'(period8), 0);
    @(negedge clk);
    sigin = DW'(-8000);
    deb_cyc = 8'd0;
    rst_n = 1'b1;
    idle(3);
    drv(8000, c);
    exp_rise(c + 2, "t6_post");
    exp_at(c + 2, K_VLD, 0, "t6_post_arm");
    idle(19);
    drv(-8000, c);
    idle(19);
    drv(8000, c);
    exp_at(c + 2, K_VLD, 1, "t6_post_vld");
    exp_at(c + 2, K_PER, 40, "t6_post_per");
    idle(5);

    idle(3);
    chk("sb_drain", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/squarewave_hyst.md
Name: squarewave_hyst

Overview:
Parametrised successor to the team's fixed-threshold square-wave slicer. It converts a signed ADC sample stream into a clean logic square wave using runtime-programmable high and low thresholds (hysteresis) and a programmable debounce hold count. It also emits edge pulses and measures the rising-edge period. It sits directly after the ADC capture logic and feeds downstream frequency and phase logic.

Parameters:
DATA_W, 14, sample and threshold width (signed two's complement)
CNT_W, 8, debounce counter width
PER_W, 24, period counter width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
en  input  1  block enable
sigin  input  DATA_W  signed input sample
th_hi  input  DATA_W  signed upper threshold; above = x > th_hi
th_lo  input  DATA_W  signed lower threshold; below = x < th_lo
deb_cyc  input  CNT_W  extra consecutive qualifying cycles required before switching
sigout  output  1  sliced square wave
rise_pulse  output  1  one-cycle pulse when sigout goes 0->1
fall_pulse  output  1  one-cycle pulse when sigout goes 1->0
period  output  PER_W  cycles between the last two rises
period_vld  output  1  one-cycle strobe; period updated
period_ovf  output  1  sticky until next period_vld; last period saturated

Behaviour:
- Reset: x=0, FSM=LOW, cnt=0, sigout=0, rise_pulse=0, fall_pulse=0, period=0, period_vld=0, period_ovf=0, armed=0.
- Stage 1: x <= sigin every cycle, regardless of en. Compares are signed and combinational on x. th_hi, th_lo and deb_cyc are used live with no shadowing.
- Defined configuration: th_lo <= th_hi+1. If above and below are both true, above wins.
- FSM states: LOW, PEND_HI, HIGH, PEND_LO. sigout is 1 in HIGH and PEND_LO, and is registered.
- LOW: if above and deb_cyc==0, go to HIGH. If above otherwise, go to PEND_HI with cnt=1.
- PEND_HI: if not above, go to LOW and clear cnt (glitch reject). Else if cnt >= deb_cyc, go to HIGH. Else increment cnt.
- HIGH and PEND_LO mirror LOW and PEND_HI, using below instead of above.
- Inside the band (th_lo <= x <= th_hi), HIGH and LOW hold.
- Latency: sigout changes 2+deb_cyc rising edges after the first qualifying sample is presented on sigin. With deb_cyc=0 this is 2 cycles, matching the legacy slicer.
- Reducing deb_cyc mid-pend: the >= compare switches on the next cycle. cnt saturates and never wraps.
- en=0:
  - PEND_HI returns to LOW and PEND_LO returns to HIGH; sigout holds.
  - cnt is cleared.
  - Edge pulses and period_vld are suppressed.
  - Period counter is cleared, armed=0, period and period_ovf hold.
- rise_pulse and fall_pulse are asserted in the same cycle sigout first shows its new value.
- Period measurement:
  - The cycle counter runs while en=1 and saturates at 2^PER_W-1.
  - On a rise with armed=0: set armed=1 and restart the count. No strobe.
  - On a rise with armed=1: period = cycle distance between this rise_pulse and the previous one. period_vld pulses coincident with rise_pulse. period_ovf is set if the count saturated (period = all ones), otherwise cleared.
  - Example: rise_pulse at cycles 10 and 35 gives period=25 with vld in cycle 35.
- Reset asserted mid-operation returns everything to reset values immediately (async). The first rise after release only arms the period measurement.

Test Plan:
1. Legacy equivalence: th_hi=5000, th_lo=5001, deb=0. sigin 4999->5001 gives sigout=1 two edges later. 5001->5000 gives sigout=0 two edges later. One rise_pulse and one fall_pulse, each 1 cycle.
2. Hysteresis: th_hi=1000, th_lo=-1000. Sequence 0, 1001, 0, 500, -1000, -1001 gives sigout 0, then 1, held through 0/500/-1000, then 0 only after -1001. Exactly one rise and one fall.
3. Debounce: deb=3, th_hi=100. Hold 200 for 3 cycles then 0: sigout stays 0, no pulses. Hold 200 for 4 cycles: sigout rises 5 edges after the first 200. Lower deb to 1 mid-pend: rises on the next edge.
4. Period: full-scale ±8000 square wave, period 40 cycles, th_hi=th_lo=0. First rise gives no vld. Each later rise gives period=40, period_vld=1, period_ovf=0. Also check a negative-only wave (-100/-8000, th=-4000).
5. Overflow: PER_W=8, two rises 300 cycles apart gives period=255, period_ovf=1. A following 50-cycle interval gives period=50, period_ovf=0.
6. Reset/en: assert rst_n low during PEND_HI, so all outputs reset asynchronously. Drop en during PEND_LO: sigout holds 1, no pulses. After en=1, the first rise only arms the period measurement.
